// File: rtl/dma_axi_pkg.sv
// dma_axi_pkg: AXI response codes, request-master states and timeout fill pattern
package dma_axi_pkg;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  localparam logic [31:0] TIMEOUT_FILL = 32'hDEADBEEF;
  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RESPOND
  } axil_state_e;
endpackage

// File: rtl/axi4_lite_timeout_cnt.sv
// axi4_lite_timeout_cnt: saturating transaction-age counter with expiry flag
module axi4_lite_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic ACLK,
  input  logic ARESETN,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && cnt != LAST) cnt <= cnt + 1'b1;
  end
  assign expired = cnt == LAST;
endmodule

// File: rtl/axi4_lite_req_master.sv
// axi4_lite_req_master: single-outstanding host register request to AXI4-Lite master bridge with timeout
module axi4_lite_req_master
  import dma_axi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   M_AWADDR,
  output logic                    M_AWVALID,
  input  logic                    M_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_WSTRB,
  output logic                    M_WVALID,
  input  logic                    M_WREADY,
  input  logic [1:0]              M_BRESP,
  input  logic                    M_BVALID,
  output logic                    M_BREADY,
  output logic [ADDR_WIDTH-1:0]   M_ARADDR,
  output logic                    M_ARVALID,
  input  logic                    M_ARREADY,
  input  logic [DATA_WIDTH-1:0]   M_RDATA,
  input  logic [1:0]              M_RRESP,
  input  logic                    M_RVALID,
  output logic                    M_RREADY
);
  axil_state_e state, state_n;
  logic aw_done, w_done, aw_done_n, w_done_n;
  logic awvalid_n, wvalid_n, arvalid_n, abort, cnt_clr, expired, to_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] wdata_n, rdata_n;
  logic [DATA_WIDTH/8-1:0] strb_n;
  logic [1:0] resp_n;
  assign req_ready = state == IDLE;
  assign M_ARADDR  = M_AWADDR;
  axi4_lite_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .clr     (cnt_clr),
    .en      (state != IDLE && state != RESPOND),
    .expired (expired)
  );
  always_comb begin
    state_n   = state;
    aw_done_n = aw_done;
    w_done_n  = w_done;
    awvalid_n = M_AWVALID;
    wvalid_n  = M_WVALID;
    arvalid_n = M_ARVALID;
    addr_n    = M_AWADDR;
    wdata_n   = M_WDATA;
    strb_n    = M_WSTRB;
    rdata_n   = rsp_rdata;
    resp_n    = rsp_resp;
    to_n      = rsp_timeout;
    cnt_clr   = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: if (req_valid) begin
        addr_n    = req_addr;
        wdata_n   = req_wdata;
        strb_n    = req_strb;
        cnt_clr   = 1'b1;
        aw_done_n = 1'b0;
        w_done_n  = 1'b0;
        awvalid_n = req_write;
        wvalid_n  = req_write;
        arvalid_n = !req_write;
        state_n   = req_write ? WR_ADDR_DATA : RD_ADDR;
      end
      WR_ADDR_DATA: begin
        aw_done_n = aw_done | (M_AWVALID & M_AWREADY);
        w_done_n  = w_done | (M_WVALID & M_WREADY);
        awvalid_n = M_AWVALID & ~M_AWREADY;
        wvalid_n  = M_WVALID & ~M_WREADY;
        if (aw_done_n && w_done_n) state_n = WR_RESP;
        else abort = expired;
      end
      WR_RESP: if (M_BVALID) begin
        rdata_n = '0;
        resp_n  = M_BRESP;
        to_n    = 1'b0;
        state_n = RESPOND;
      end else abort = expired;
      RD_ADDR: if (M_ARREADY) begin
        arvalid_n = 1'b0;
        state_n   = RD_DATA;
      end else abort = expired;
      RD_DATA: if (M_RVALID) begin
        rdata_n = M_RDATA;
        resp_n  = M_RRESP;
        to_n    = 1'b0;
        state_n = RESPOND;
      end else abort = expired;
      RESPOND: if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // a hung slave is abandoned: VALIDs are withdrawn mid-handshake on purpose
    if (abort) begin
      awvalid_n = 1'b0;
      wvalid_n  = 1'b0;
      arvalid_n = 1'b0;
      rdata_n   = DATA_WIDTH'(TIMEOUT_FILL);
      resp_n    = AXI_RESP_SLVERR;
      to_n      = 1'b1;
      state_n   = RESPOND;
    end
  end
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state       <= IDLE;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      M_AWVALID   <= 1'b0;
      M_WVALID    <= 1'b0;
      M_ARVALID   <= 1'b0;
      M_AWADDR    <= '0;
      M_WDATA     <= '0;
      M_WSTRB     <= '0;
      M_BREADY    <= 1'b1;
      M_RREADY    <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= AXI_RESP_OKAY;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      aw_done     <= aw_done_n;
      w_done      <= w_done_n;
      M_AWVALID   <= awvalid_n;
      M_WVALID    <= wvalid_n;
      M_ARVALID   <= arvalid_n;
      M_AWADDR    <= addr_n;
      M_WDATA     <= wdata_n;
      M_WSTRB     <= strb_n;
      M_BREADY    <= state_n == IDLE || state_n == WR_RESP;
      M_RREADY    <= state_n == IDLE || state_n == RD_DATA;
      rsp_valid   <= state_n == RESPOND;
      rsp_rdata   <= rdata_n;
      rsp_resp    <= resp_n;
      rsp_timeout <= to_n;
    end
  end
endmodule

// File: tb/tb_axi4_lite_req_master.sv
// tb_axi4_lite_req_master: scoreboard bench with a stub register slave behind the request master
module tb_axi4_lite_req_master;
  localparam int T = 16;
  logic ACLK = 0, ARESETN = 0;
  logic req_valid = 0, req_ready, req_write = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [3:0] req_strb = 0;
  logic rsp_valid, rsp_ready = 1, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic [31:0] M_AWADDR, M_WDATA, M_ARADDR, M_RDATA = 0;
  logic [3:0] M_WSTRB;
  logic M_AWVALID, M_AWREADY = 0, M_WVALID, M_WREADY = 0;
  logic [1:0] M_BRESP = 0, M_RRESP = 0;
  logic M_BVALID = 0, M_BREADY, M_ARVALID, M_ARREADY = 0, M_RVALID = 0, M_RREADY;
  always #5 ACLK = ~ACLK;
  axi4_lite_req_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
    .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
  );
  typedef struct packed {logic [31:0] rdata; logic [1:0] resp; logic to;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  logic [31:0] smem[2] = '{32'h0, 32'h0};
  logic [31:0] refm[2] = '{32'h0, 32'h0};
  int aw_lat = 0, w_lat = 0;
  bit hung = 0;
  int aw_wt = 0, w_wt = 0, aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0;
  bit got_aw = 0, got_w = 0, b_sched = 0, r_sched = 0, b_fire = 0, r_fire = 0;
  logic [31:0] s_awaddr = 0, s_wdata = 0, s_araddr = 0;
  logic [3:0] s_wstrb = 0;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // stub slave: regs at 0x0/0x4, DECERR at 0x10, SLVERR elsewhere
  function automatic logic [1:0] code(logic [31:0] a);
    return a < 8 ? 2'b00 : a == 32'h10 ? 2'b11 : 2'b10;
  endfunction
  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] d, logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) o[8*i+:8] = d[8*i+:8];
    return o;
  endfunction
  always @(negedge ACLK) begin
    if (!ARESETN) begin
      M_AWREADY = 0; M_WREADY = 0; M_ARREADY = 0; M_BVALID = 0; M_RVALID = 0;
      got_aw = 0; got_w = 0; b_sched = 0; r_sched = 0; b_fire = 0; r_fire = 0;
      aw_wt = 0; w_wt = 0;
    end else begin
      if (b_fire) begin M_BVALID = 0; b_hs_n++; end
      if (r_fire) M_RVALID = 0;
      if (b_sched) begin M_BVALID = 1; M_BRESP = code(s_awaddr); b_sched = 0; end
      if (r_sched) begin
        M_RVALID = 1;
        M_RDATA = s_araddr < 8 ? smem[s_araddr[2]] : 32'h0;
        M_RRESP = code(s_araddr);
        r_sched = 0;
      end
      aw_wt = M_AWVALID ? aw_wt + 1 : 0;
      w_wt = M_WVALID ? w_wt + 1 : 0;
      M_AWREADY = !hung && M_AWVALID && aw_wt > aw_lat;
      M_WREADY = !hung && M_WVALID && w_wt > w_lat;
      M_ARREADY = !hung && M_ARVALID;
      if (M_AWVALID && M_AWREADY) begin got_aw = 1; s_awaddr = M_AWADDR; aw_hs_n++; end
      if (M_WVALID && M_WREADY) begin got_w = 1; s_wdata = M_WDATA; s_wstrb = M_WSTRB; w_hs_n++; end
      if (got_aw && got_w) begin
        if (s_awaddr < 8) smem[s_awaddr[2]] = merge(smem[s_awaddr[2]], s_wdata, s_wstrb);
        b_sched = 1; got_aw = 0; got_w = 0;
      end
      if (M_ARVALID && M_ARREADY) begin s_araddr = M_ARADDR; r_sched = 1; end
      b_fire = M_BVALID && M_BREADY;
      r_fire = M_RVALID && M_RREADY;
    end
  end
  always @(negedge ACLK) begin
    if (ARESETN && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) chk("unexpected_rsp", {32'h0, rsp_rdata}, 64'h0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_resp", rsp_resp, e.resp);
        chk("rsp_timeout", rsp_timeout, e.to);
      end
    end
  end
  task automatic do_req(bit wr, logic [31:0] a, logic [31:0] d, logic [3:0] s, bit to);
    exp_t e;
    bit acc = 0;
    if (to) e = '{32'hDEADBEEF, 2'b10, 1'b0};
    else if (wr) e = '{32'h0, code(a), 1'b0};
    else e = '{a < 8 ? refm[a[2]] : 32'h0, code(a), 1'b0};
    e.to = to;
    if (wr && !to && a < 8) refm[a[2]] = merge(refm[a[2]], d, s);
    sb.push_back(e);
    req_write = wr; req_addr = a; req_wdata = d; req_strb = s; req_valid = 1;
    for (int i = 0; i < 100 && !acc; i++) begin
      acc = req_ready;
      @(posedge ACLK); #1;
    end
    req_valid = 0;
    chk("accept", acc, 1);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 100 && !(sb.size() == 0 && req_ready); i++) begin
      @(posedge ACLK); #1;
    end
    chk("drain", sb.size(), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    int ba, bw, bb;
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_awvalid", M_AWVALID, 0);
    chk("rst_wvalid", M_WVALID, 0);
    chk("rst_arvalid", M_ARVALID, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_resp", rsp_resp, 0);
    chk("rst_timeout", rsp_timeout, 0);
    ARESETN = 1;
    @(posedge ACLK); #1;
    do_req(1, 32'h4, 32'hCAFEBABE, 4'hF, 0); wait_idle();
    do_req(0, 32'h4, 0, 0, 0); wait_idle();
    do_req(0, 32'h8, 0, 0, 0); wait_idle();
    do_req(0, 32'h10, 0, 0, 0); wait_idle();
    do_req(1, 32'h8, 32'h11111111, 4'hF, 0); wait_idle();
    do_req(1, 32'h4, 32'h12345678, 4'h3, 0); wait_idle();
    do_req(0, 32'h4, 0, 0, 0); wait_idle();
    ba = aw_hs_n; bw = w_hs_n; bb = b_hs_n;
    aw_lat = 3;
    do_req(1, 32'h0, 32'hA5A5A5A5, 4'hF, 0); wait_idle();
    aw_lat = 0;
    do_req(1, 32'h0, 32'h0F0F0F0F, 4'hC, 0); wait_idle();
    w_lat = 2;
    do_req(1, 32'h0, 32'h5A5A5A5A, 4'h1, 0); wait_idle();
    w_lat = 0;
    chk("aw_hs_count", aw_hs_n - ba, 3);
    chk("w_hs_count", w_hs_n - bw, 3);
    chk("b_hs_count", b_hs_n - bb, 3);
    do_req(0, 32'h0, 0, 0, 0); wait_idle();
    rsp_ready = 0;
    do_req(0, 32'h4, 0, 0, 0);
    for (int i = 0; i < 40 && !rsp_valid; i++) begin @(posedge ACLK); #1; end
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", rsp_valid, 1);
      chk("stall_rdata", rsp_rdata, 32'hCAFE5678);
      chk("stall_req_ready", req_ready, 0);
      @(posedge ACLK); #1;
    end
    rsp_ready = 1;
    chk("release_req_ready", req_ready, 0);
    @(posedge ACLK); #1;
    chk("after_req_ready", req_ready, 1);
    chk("after_rsp_valid", rsp_valid, 0);
    wait_idle();
    hung = 1; rsp_ready = 0;
    do_req(0, 32'h4, 0, 0, 1);
    for (n = 1; n <= 40; n++) begin
      @(posedge ACLK); #1;
      if (rsp_valid) break;
    end
    chk("to_latency", n, T);
    chk("to_arvalid", M_ARVALID, 0);
    chk("to_flag", rsp_timeout, 1);
    hung = 0; rsp_ready = 1;
    wait_idle();
    aw_lat = 8;
    do_req(1, 32'h0, 32'h77777777, 4'hF, 0);
    chk("pre_rst_awvalid", M_AWVALID, 1);
    #2 ARESETN = 0;
    #1;
    chk("async_awvalid", M_AWVALID, 0);
    chk("async_wvalid", M_WVALID, 0);
    chk("async_arvalid", M_ARVALID, 0);
    chk("async_rsp_valid", rsp_valid, 0);
    chk("async_req_ready", req_ready, 1);
    sb.delete();
    repeat (2) @(posedge ACLK);
    #1 ARESETN = 1;
    aw_lat = 0;
    @(posedge ACLK); #1;
    chk("post_rst_req_ready", req_ready, 1);
    do_req(0, 32'h4, 0, 0, 0); wait_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi4_lite_req_master.md
Name: axi4_lite_req_master

Overview:
- Upstream neighbour of the DMA's AXI4-Lite test/config register slaves.
- Converts single-beat host register requests (decoded from PCIe by the DMA engine) into AXI4-Lite master read/write transactions.
- Returns data and response codes to the host, one transaction outstanding at a time.
- A timeout guarantees the host side never hangs on an unresponsive slave.

Parameters:
DATA_WIDTH, 32, AXI4-Lite and request data width
ADDR_WIDTH, 32, AXI4-Lite and request address width
TIMEOUT_CYCLES, 1024, cycles after leaving IDLE before the transaction is aborted (>=4)

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
req_valid  in  1  host request valid
req_ready  out  1  request accepted when req_valid & req_ready
req_write  in  1  1=write, 0=read
req_addr  in  ADDR_WIDTH  target address
req_wdata  in  DATA_WIDTH  write data
req_strb  in  DATA_WIDTH/8  write byte strobes
rsp_valid  out  1  response valid, held until rsp_ready
rsp_ready  in  1  host accepts response
rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
rsp_resp  out  2  AXI response code (OKAY=00, SLVERR=10)
rsp_timeout  out  1  transaction aborted by timeout
M_AWADDR/M_AWVALID/M_AWREADY  out/out/in  ADDR_WIDTH/1/1  write address channel
M_WDATA/M_WSTRB/M_WVALID/M_WREADY  out/out/out/in  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel
M_BRESP/M_BVALID/M_BREADY  in/in/out  2/1/1  write response channel
M_ARADDR/M_ARVALID/M_ARREADY  out/out/in  ADDR_WIDTH/1/1  read address channel
M_RDATA/M_RRESP/M_RVALID/M_RREADY  in/in/in/out  DATA_WIDTH/2/1/1  read data channel

Behaviour:
- Reset (async, ARESETN=0): state IDLE. All M_*VALID=0, rsp_valid=0, rsp_rdata=0, rsp_resp=00, rsp_timeout=0, timeout counter=0, addresses/data=0. Takes effect immediately, mid-transaction included; no completion is reported for an aborted transaction.
- All outputs are registered except req_ready=(state==IDLE).
- States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESPOND.
- IDLE:
  - On accept: latch addr/wdata/strb, clear counter.
  - Write -> WR_ADDR_DATA with M_AWVALID=M_WVALID=1 in the next cycle. Read -> RD_ADDR with M_ARVALID=1 in the next cycle.
  - M_BREADY=M_RREADY=1 in IDLE to drain stale responses from timed-out transactions.
- WR_ADDR_DATA:
  - AW and W complete independently. Flags aw_done/w_done are set on each handshake, and that VALID drops the cycle after its handshake.
  - Any order is allowed, including the same cycle. When both are done -> WR_RESP.
- WR_RESP: M_BREADY=1. On M_BVALID, capture M_BRESP, rdata=0 -> RESPOND.
- RD_ADDR: hold M_ARVALID until M_ARREADY -> RD_DATA.
- RD_DATA: M_RREADY=1. On M_RVALID, capture M_RDATA and M_RRESP -> RESPOND.
- RESPOND:
  - rsp_valid=1 with stable payload until rsp_ready, then -> IDLE. req_ready returns high the following cycle.
  - Back-to-back throughput is therefore 1 transaction per (channel latency + 2) cycles minimum.
- Timeout:
  - The counter increments every cycle in WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA.
  - When it reaches TIMEOUT_CYCLES-1 without completing: drop all M_*VALID, go to RESPOND with rsp_timeout=1, rsp_resp=10, rsp_rdata=32'hDEADBEEF (lower DATA_WIDTH bits).
  - A completion handshake in the same cycle as expiry wins; the normal response is returned.
  - The counter does not run in IDLE or RESPOND; it saturates and never wraps.
- Dropping VALID on timeout is a deliberate protocol exception for hung slaves only.
- M_BRESP/M_RRESP of 01 or 11 are passed through unchanged in rsp_resp.

Decomposition:
- Shared package (dma_axi_pkg): AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR constants, the state enum, and the TIMEOUT_FILL=32'hDEADBEEF constant. The register slave uses the same response constants.
- One sub-module, axi4_lite_timeout_cnt: clear/enable inputs, saturating counter, expired output.
- The FSM and channel logic stay in the top module.

Test Plan:
- Write 0xCAFEBABE, strb 0xF, to addr 0x4 on the DMA test-register slave, then read 0x4 -> write rsp_resp=00, rsp_rdata=0; read rsp_rdata=0xCAFEBABE, rsp_resp=00, rsp_timeout=0.
- Read unimplemented addr 0x8 on the test-register slave -> rsp_resp=10, rsp_timeout=0.
- Stub slave with W handshake 3 cycles before AW, then same-cycle AW/W -> exactly one AW and one W handshake each; BRESP 00 returned once per write.
- TIMEOUT_CYCLES=16, slave with all READY tied 0, read request -> rsp_valid 16 cycles after acceptance with rdata=0xDEADBEEF, rsp_resp=10, rsp_timeout=1; M_ARVALID low in RESPOND.
- Hold rsp_ready=0 for 10 cycles after completion -> rsp_valid and payload stable throughout, req_ready=0 until one cycle after rsp_ready.
- Assert ARESETN=0 while M_AWVALID=1 -> all VALIDs and rsp_valid low in the same cycle (async); after release, req_ready=1 and a new read completes correctly.
